sync_fifo_prog: RTL and testbench

Parametrised synchronous FIFO with an internal storage array, a fill-level count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It is the successor to the basic pointer-compare FIFO and is the standard single-clock buffer between streaming producers and consumers in the datapath. A compile-time option switches the read port from registered-read to first-word-fall-through (FWFT).

---
 rtl/sync_fifo_prog.sv | 110 +++++++++++
 tb/tb_sync_fifo_prog.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with fill count, programmable almost-full/almost-empty and sticky error flags.
// Define FIFO_FWFT_EN for a first-word-fall-through read port; the default is registered read.
module sync_fifo_prog #(
   parameter int DWIDTH    = 32,
   parameter int ADEPTH    = 5,
   parameter int AF_THRESH = 2**ADEPTH-2,
   parameter int AE_THRESH = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              WR_EN,
   input  logic [DWIDTH-1:0] DIN,
   output logic              FULL,
   output logic              ALMOST_FULL,
   output logic              OVERFLOW,
   input  logic              RD_EN,
   output logic [DWIDTH-1:0] DOUT,
   output logic              EMPTY,
   output logic              ALMOST_EMPTY,
   output logic              UNDERFLOW,
   output logic [ADEPTH:0]   COUNT,
   input  logic              CLR_ERR
);

   localparam int              DEPTH   = 2**ADEPTH;
   localparam logic [ADEPTH:0] DEPTH_C = (ADEPTH+1)'(DEPTH);
   localparam logic [ADEPTH:0] AF_C    = (ADEPTH+1)'(AF_THRESH);
   localparam logic [ADEPTH:0] AE_C    = (ADEPTH+1)'(AE_THRESH);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [ADEPTH:0]   wr_ptr;
   logic [ADEPTH:0]   rd_ptr;
   logic              wr_acc;
   logic              rd_acc;
   logic              arr_pop;

   function automatic logic [ADEPTH:0] next_count(input logic [ADEPTH:0] c,
                                                  input logic w, input logic r);
      case ({w, r})
         2'b10:   return c + 1'b1;
         2'b01:   return c - 1'b1;
         default: return c;
      endcase
   endfunction

   assign FULL         = (COUNT == DEPTH_C);
   assign ALMOST_FULL  = (COUNT >= AF_C);
   assign ALMOST_EMPTY = (COUNT <= AE_C);
   assign wr_acc       = WR_EN & ~FULL;

`ifdef FIFO_FWFT_EN
   // Output register holds the head word; COUNT includes it, so the array never exceeds DEPTH-1 then.
   logic            out_vld_p1;
   logic [ADEPTH:0] arr_cnt;

   assign arr_cnt = wr_ptr - rd_ptr;
   assign EMPTY   = ~out_vld_p1;
   assign rd_acc  = RD_EN & out_vld_p1;
   assign arr_pop = (~out_vld_p1 | rd_acc) & (arr_cnt != '0);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         out_vld_p1 <= 1'b0;
         DOUT       <= '0;
      end else if (arr_pop) begin
         out_vld_p1 <= 1'b1;
         DOUT       <= mem[rd_ptr[ADEPTH-1:0]];
      end else if (rd_acc) begin
         out_vld_p1 <= 1'b0;
      end
   end
`else
   assign EMPTY   = (COUNT == '0);
   assign rd_acc  = RD_EN & ~EMPTY;
   assign arr_pop = rd_acc;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         DOUT <= '0;
      else if (rd_acc)
         DOUT <= mem[rd_ptr[ADEPTH-1:0]];
   end
`endif

   // Storage array: not reset, written only on accepted writes.
   always_ff @(posedge CLK) begin
      if (wr_acc)
         mem[wr_ptr[ADEPTH-1:0]] <= DIN;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         COUNT     <= '0;
         OVERFLOW  <= 1'b0;
         UNDERFLOW <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (arr_pop)
            rd_ptr <= rd_ptr + 1'b1;
         COUNT     <= next_count(COUNT, wr_acc, rd_acc);
         // A new error in the same cycle as CLR_ERR keeps the flag set.
         OVERFLOW  <= (WR_EN & FULL)  | (OVERFLOW  & ~CLR_ERR);
         UNDERFLOW <= (RD_EN & EMPTY) | (UNDERFLOW & ~CLR_ERR);
      end
   end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: directed and random traffic against a queue-based reference model.
// A second instance with AF_THRESH=4, AE_THRESH=0 shares the stimulus to cover threshold decoding.
module tb_sync_fifo_prog;

   localparam int DEPTH = 32;
`ifdef FIFO_FWFT_EN
   localparam bit FWFT = 1'b1;
`else
   localparam bit FWFT = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        WR_EN = 1'b0;
   logic        RD_EN = 1'b0;
   logic        CLR_ERR = 1'b0;
   logic [31:0] DIN = '0;

   logic [31:0] DOUT, t_dout;
   logic [5:0]  COUNT, t_count;
   logic FULL, ALMOST_FULL, OVERFLOW, EMPTY, ALMOST_EMPTY, UNDERFLOW;
   logic t_full, t_af, t_ovf, t_empty, t_ae, t_unf;

   int total = 0;
   int bad   = 0;

   // Reference model: queue of words in the array plus (FWFT only) the presented head word.
   logic [31:0] q[$];
   logic [31:0] e_dout;
   bit          o_vld;
   bit          e_ovf, e_unf;

   sync_fifo_prog #(.DWIDTH(32), .ADEPTH(5)) dut (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .DIN(DIN), .FULL(FULL),
      .ALMOST_FULL(ALMOST_FULL), .OVERFLOW(OVERFLOW), .RD_EN(RD_EN), .DOUT(DOUT),
      .EMPTY(EMPTY), .ALMOST_EMPTY(ALMOST_EMPTY), .UNDERFLOW(UNDERFLOW),
      .COUNT(COUNT), .CLR_ERR(CLR_ERR)
   );

   sync_fifo_prog #(.DWIDTH(32), .ADEPTH(5), .AF_THRESH(4), .AE_THRESH(0)) u_thr (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .DIN(DIN), .FULL(t_full),
      .ALMOST_FULL(t_af), .OVERFLOW(t_ovf), .RD_EN(RD_EN), .DOUT(t_dout),
      .EMPTY(t_empty), .ALMOST_EMPTY(t_ae), .UNDERFLOW(t_unf),
      .COUNT(t_count), .CLR_ERR(CLR_ERR)
   );

   always #5 CLK = ~CLK;

   function automatic int m_count();
      return q.size() + (FWFT ? int'(o_vld) : 0);
   endfunction

   function automatic bit m_empty();
      return FWFT ? !o_vld : (m_count() == 0);
   endfunction

   task automatic model_reset();
      q.delete();
      e_dout = '0;
      o_vld  = 1'b0;
      e_ovf  = 1'b0;
      e_unf  = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int c;
      c = m_count();
      chk("count",     64'(COUNT),        64'(c));
      chk("full",      64'(FULL),         64'(c == DEPTH));
      chk("empty",     64'(EMPTY),        64'(m_empty()));
      chk("alm_full",  64'(ALMOST_FULL),  64'(c >= 30));
      chk("alm_empty", 64'(ALMOST_EMPTY), 64'(c <= 2));
      chk("overflow",  64'(OVERFLOW),     64'(e_ovf));
      chk("underflow", 64'(UNDERFLOW),    64'(e_unf));
      chk("dout",      64'(DOUT),         64'(e_dout));
      chk("thr_af",    64'(t_af),         64'(c >= 4));
      chk("thr_ae",    64'(t_ae),         64'(c <= 0));
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, check 1 time unit later.
   task automatic cyc(input bit w, input logic [31:0] d, input bit r, input bit clr);
      int c;
      bit full_m, empty_m, wa, ra, had;
      WR_EN = w; DIN = d; RD_EN = r; CLR_ERR = clr;
      c       = m_count();
      full_m  = (c == DEPTH);
      empty_m = m_empty();
      wa      = w && !full_m;
      ra      = r && !empty_m;
      @(posedge CLK);
      e_ovf = (w && full_m)  || (e_ovf && !clr);
      e_unf = (r && empty_m) || (e_unf && !clr);
      if (FWFT) begin
         had = (q.size() > 0);
         if ((!o_vld || ra) && had) begin
            e_dout = q.pop_front();
            o_vld  = 1'b1;
         end else if (ra) begin
            o_vld = 1'b0;
         end
      end else if (ra) begin
         e_dout = q.pop_front();
      end
      if (wa)
         q.push_back(d);
      #1;
      check_all();
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && m_count() > 0; k++)
         cyc(1'b0, '0, 1'b1, 1'b0);
      chk("drained_count", 64'(COUNT), 64'd0);
   endtask

   initial begin
      int c;
      // Reset and idle
      model_reset();
      #3;
      check_all();
      #9 RST = 1'b1;
      cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);

      // Fill 0..31, then overflow, then read+write while full
      for (int i = 0; i < 32; i++)
         cyc(1'b1, 32'(i), 1'b0, 1'b0);
      chk("filled_full", 64'(FULL), 64'd1);
      cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      chk("ovf_count", 64'(COUNT), 64'd32);
      cyc(1'b1, 32'h12345678, 1'b1, 1'b0);
      chk("simul_full_count", 64'(COUNT), 64'd31);
      drain();

      // Underflow, clear, read+write while empty
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1);
      chk("clr_ovf", 64'(OVERFLOW), 64'd0);
      cyc(1'b1, 32'hCAFE0001, 1'b1, 1'b0);
      chk("simul_empty_count", 64'(COUNT), 64'd1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      drain();

      // Steady state at COUNT=10 across pointer wrap
      for (int i = 0; i < 10; i++)
         cyc(1'b1, $urandom, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++)
         cyc(1'b1, $urandom, 1'b1, 1'b0);
      chk("steady_count", 64'(COUNT), 64'd10);

      // Random traffic including occasional error clears
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45,
             $urandom_range(0, 99) < 5);

      // Steer to COUNT=17, then asynchronous reset between edges
      for (int k = 0; k < 300 && m_count() != 17; k++) begin
         c = m_count();
         cyc(c < 17, $urandom, c > 17, 1'b0);
      end
      chk("pre_reset_count", 64'(COUNT), 64'd17);
      #2 RST = 1'b0;
      #1;
      model_reset();
      check_all();
      #3 RST = 1'b1;
      cyc(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      chk("first_after_reset", 64'(DOUT), 64'hA5A5A5A5);

      // Walk through the low thresholds of the second instance
      for (int i = 0; i < 6; i++)
         cyc(1'b1, $urandom, 1'b0, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
